// File: rtl/scope_pkg.sv
// scope_pkg: shared capture FSM state encoding and default widths for the scope capture controller
package scope_pkg;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int DEPTH_WIDTH_DEF = 10;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_FILL = 3'd1,
    ARMED    = 3'd2,
    POST     = 3'd3,
    DRAIN    = 3'd4,
    FLUSH    = 3'd5
  } state_e;
endpackage

// File: rtl/scope_out_stage.sv
// scope_out_stage: one-read-in-flight tracker and valid/ready output register for the FIFO drain
// ports: rd_req_i read issued this cycle, rd_data_i FIFO data (valid the cycle after a read), clr_i flush,
//        ready_i/valid_o/data_o host handshake, inflight_o read outstanding, can_read_o next read allowed
module scope_out_stage #(
  parameter int c_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    rd_req_i,
  input  logic [c_DATA_WIDTH-1:0] rd_data_i,
  input  logic                    ready_i,
  output logic [c_DATA_WIDTH-1:0] data_o,
  output logic                    valid_o,
  output logic                    inflight_o,
  output logic                    can_read_o
);
  logic [c_DATA_WIDTH-1:0] data_q;
  logic                    valid_q;
  logic                    inflight_q;

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign inflight_o = inflight_q;
  // a new read is only issued when the register will be free by the time its data lands
  assign can_read_o = !inflight_q && (!valid_q || ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else if (clr_i) begin
      valid_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_req_i;
      if (inflight_q) begin
        data_q  <= rd_data_i;
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: pre/post-trigger sample capture into an external synchronous FIFO, then drain to host
// ports: arm/abort control, pre_num/post_num window, smp_* sample stream, fifo_* external FIFO,
//        out_* host stream, busy/done/ovf status
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int c_DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int c_DEPTH_WIDTH = DEPTH_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [c_DEPTH_WIDTH-1:0] pre_num,
  input  logic [c_DEPTH_WIDTH:0]   post_num,
  input  logic [c_DATA_WIDTH-1:0]  smp_data,
  input  logic                     smp_valid,
  input  logic                     trig,
  output logic                     fifo_wr_en,
  output logic [c_DATA_WIDTH-1:0]  fifo_wr_data,
  input  logic                     fifo_full,
  output logic                     fifo_rd_en,
  input  logic [c_DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                     fifo_empty,
  output logic                     fifo_clr,
  output logic [c_DATA_WIDTH-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);
  localparam int OW = c_DEPTH_WIDTH + 1;

  state_e        state_q;
  logic [OW-1:0] occ_q, occ_d, post_q, post_inc, post_eff;
  logic          done_q, ovf_q, busy_q, clr_q;
  logic          flush, discard, drain_rd, can_read, inflight;

  assign post_eff = (post_num == '0) ? OW'(1) : post_num;
  assign post_inc = post_q + OW'(1);
  assign flush    = abort && state_q != IDLE && state_q != FLUSH;
  // in ARMED with no pre-trigger window nothing is retained until the trigger sample
  assign fifo_wr_en = !flush && smp_valid && (state_q == PRE_FILL ||
                      (state_q == ARMED && (trig || pre_num != '0)) ||
                      (state_q == POST && !fifo_full));
  assign fifo_wr_data = smp_data;
  // sliding pre-trigger window: each new sample pushes out the oldest one
  assign discard  = !flush && smp_valid && state_q == ARMED && !trig && pre_num != '0;
  assign drain_rd = !flush && state_q == DRAIN && !fifo_empty && can_read;
  assign fifo_rd_en = discard || drain_rd;
  assign occ_d = occ_q + OW'(fifo_wr_en) - OW'(fifo_rd_en);

  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign fifo_clr = clr_q;

  scope_out_stage #(.c_DATA_WIDTH(c_DATA_WIDTH)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (flush),
    .rd_req_i   (drain_rd),
    .rd_data_i  (fifo_rd_data),
    .ready_i    (out_ready),
    .data_o     (out_data),
    .valid_o    (out_valid),
    .inflight_o (inflight),
    .can_read_o (can_read)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      occ_q   <= '0;
      post_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      occ_q  <= occ_d;
      if (flush) begin
        state_q <= FLUSH;
        clr_q   <= 1'b1;
        occ_q   <= '0;
        post_q  <= '0;
      end else begin
        case (state_q)
          IDLE: if (arm && !abort) begin
            state_q <= (pre_num == '0) ? ARMED : PRE_FILL;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            post_q  <= '0;
          end
          PRE_FILL: if (fifo_wr_en && occ_d == OW'(pre_num)) state_q <= ARMED;
          ARMED: if (smp_valid && trig) begin
            post_q  <= OW'(1);
            state_q <= (post_num <= OW'(1)) ? DRAIN : POST;
          end
          POST: if (smp_valid && fifo_full) begin
            ovf_q   <= 1'b1;
            state_q <= DRAIN;
          end else if (smp_valid) begin
            post_q <= post_inc;
            if (post_inc >= post_eff) state_q <= DRAIN;
          end
          DRAIN: if (fifo_empty && !inflight && !out_valid) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            post_q  <= '0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb_scope_capture_ctrl: directed scoreboard bench for scope_capture_ctrl with a behavioural 1024-deep FIFO
module tb_scope_capture_ctrl;
  logic        clk, rst_n, arm, abort, smp_valid, trig, out_ready;
  logic [9:0]  pre_num;
  logic [10:0] post_num;
  logic [7:0]  smp_data, fifo_wr_data, fifo_rd_data, out_data;
  logic        fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty, fifo_clr;
  logic        out_valid, busy, done, ovf;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int wc = 0;
  bit tog = 0;
  bit stall_q = 0;
  logic [7:0] held, mon_e;
  logic [7:0] exp_q[$];
  logic [7:0] fq[$];

  scope_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .pre_num(pre_num), .post_num(post_num),
    .smp_data(smp_data), .smp_valid(smp_valid), .trig(trig),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_clr(fifo_clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .ovf(ovf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_rd_data <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
    end else if (fifo_clr) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (fifo_wr_en && fq.size() < 1024) fq.push_back(fifo_wr_data);
      fifo_empty <= (fq.size() == 0);
      fifo_full  <= (fq.size() == 1024);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) stall_q = 0;
    else begin
      if (done) done_cnt++;
      if (stall_q) begin
        vectors++;
        assert (out_valid === 1'b1 && out_data === held) else begin
          miscompares++;
          $error("FAIL hold: got valid=%0b data=%0h expected valid=1 data=%0h", out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        wc++;
        vectors++;
        assert (exp_q.size() > 0) else begin
          miscompares++;
          $error("FAIL extra_word: got %0h expected no word", out_data);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          vectors++;
          assert (out_data === mon_e) else begin
            miscompares++;
            $error("FAIL out_data: got %0h expected %0h", out_data, mon_e);
          end
        end
      end
      stall_q = out_valid && !out_ready;
      held = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) out_ready = !out_ready;
  endtask

  task automatic drive(input int nsamp, input int trig_at);
    for (int i = 0; i < nsamp; i++) begin
      smp_data = 8'(i);
      smp_valid = 1;
      trig = (i == trig_at);
      step();
      if (i % 5 == 4) begin
        smp_valid = 0;
        trig = 0;
        step();
      end
    end
    smp_valid = 0;
    trig = 0;
  endtask

  task automatic run_capture(input int pre, input int post, input int trig_at, input bit togm, input bit exp_ovf);
    int pe, first, n, d0, w0;
    pe = (post == 0) ? 1 : post;
    first = trig_at - pre;
    n = pre + pe;
    if (n > 1024) n = 1024;
    for (int k = 0; k < n; k++) exp_q.push_back(8'(first + k));
    d0 = done_cnt;
    w0 = wc;
    tog = togm;
    pre_num = 10'(pre);
    post_num = 11'(post);
    arm = 1;
    step();
    arm = 0;
    chk("busy_after_arm", busy, 1);
    chk("ovf_cleared_by_arm", ovf, 0);
    drive(trig_at + pe + 3, trig_at);
    for (int k = 0; k < 6000 && done_cnt == d0; k++) step();
    chk("done_seen", done_cnt != d0, 1);
    repeat (4) step();
    tog = 0;
    out_ready = 1;
    chk("done_once", done_cnt - d0, 1);
    chk("words_out", wc - w0, n);
    chk("sb_empty", exp_q.size(), 0);
    chk("ovf", ovf, exp_ovf);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int d0;
    rst_n = 0; arm = 0; abort = 0; smp_valid = 1; trig = 0; out_ready = 1;
    pre_num = 4; post_num = 4; smp_data = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fifo_clr", fifo_clr, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    smp_valid = 0;
    rst_n = 1;
    step();

    arm = 1; abort = 1;
    step();
    arm = 0; abort = 0;
    chk("arm_abort_idle_busy", busy, 0);
    chk("arm_abort_idle_clr", fifo_clr, 0);

    run_capture(4, 4, 10, 0, 0);
    run_capture(0, 3, 5, 0, 0);
    run_capture(3, 0, 3, 0, 0);
    run_capture(2, 1, 6, 0, 0);
    run_capture(5, 6, 9, 1, 0);

    d0 = done_cnt;
    pre_num = 4; post_num = 4;
    arm = 1;
    step();
    arm = 0;
    drive(8, 100);
    abort = 1;
    arm = 1;
    step();
    abort = 0;
    arm = 0;
    chk("abort_clr", fifo_clr, 1);
    chk("abort_busy_flush", busy, 1);
    chk("abort_out_valid", out_valid, 0);
    step();
    chk("abort_clr_one", fifo_clr, 0);
    chk("abort_busy_next", busy, 0);
    chk("abort_fifo_empty", fifo_empty, 1);
    repeat (3) step();
    chk("abort_no_done", done_cnt - d0, 0);
    run_capture(4, 4, 10, 0, 0);

    run_capture(1000, 100, 1000, 0, 1);

    pre_num = 2; post_num = 50;
    arm = 1;
    step();
    arm = 0;
    drive(10, 3);
    smp_valid = 1;
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_fifo_clr", fifo_clr, 0);
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    smp_valid = 0;
    step();
    rst_n = 1;
    step();
    run_capture(4, 4, 12, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/scope_capture_ctrl.md
SCOPE_CAPTURE_CTRL -- requirements
Module: scope_capture_ctrl

Interface
REQ-001 SHALL have parameter c_DATA_WIDTH, default 8, sample width.
REQ-002 SHALL have parameter c_DEPTH_WIDTH, default 10, FIFO address width; capacity 2^c_DEPTH_WIDTH words.
REQ-003 SHALL have port clk  in  1  single clock for all logic; FIFO is instantiated as "SYN" on the same clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports arm  in  1  start-capture pulse; abort  in  1  cancel and flush.
REQ-006 SHALL have ports pre_num  in  c_DEPTH_WIDTH  pre-trigger samples; post_num  in  c_DEPTH_WIDTH+1  post-trigger samples, trigger sample included.
REQ-007 SHALL have ports smp_data  in  c_DATA_WIDTH; smp_valid  in  1; trig  in  1  trigger qualifier, sampled only with smp_valid.
REQ-008 SHALL have FIFO-side ports fifo_wr_en out 1; fifo_wr_data out c_DATA_WIDTH; fifo_full in 1; fifo_rd_en out 1; fifo_rd_data in c_DATA_WIDTH; fifo_empty in 1; fifo_clr out 1.
REQ-009 SHALL have host-side ports out_data out c_DATA_WIDTH; out_valid out 1; out_ready in 1; busy out 1; done out 1; ovf out 1.

Function
REQ-010 SHALL implement states IDLE, PRE_FILL, ARMED, POST, DRAIN, FLUSH.
REQ-011 IDLE: arm -> PRE_FILL, or ARMED if pre_num==0; arm outside IDLE is ignored.
REQ-012 fifo_wr_en SHALL be combinational smp_valid in PRE_FILL/ARMED/POST, subject to REQ-013..016; fifo_wr_data = smp_data.
REQ-013 SHALL track occupancy occ (c_DEPTH_WIDTH+1 bits) internally: +1 per write, -1 per read, unchanged on simultaneous write+read.
REQ-014 PRE_FILL: write each valid sample; trig ignored; occ reaching pre_num -> ARMED.
REQ-015 ARMED, smp_valid and no trig: if pre_num>0, write sample and assert fifo_rd_en same cycle (discard oldest, occ constant); if pre_num==0, no write.
REQ-016 ARMED, smp_valid and trig: write sample, no discard, post counter loaded with 1, -> POST; if post_num<=1, -> DRAIN directly.
REQ-017 POST: write each valid sample; post counter reaching post_num (0 treated as 1) -> DRAIN; fifo_full while writing -> set ovf, suppress write, -> DRAIN.
REQ-018 DRAIN: fifo_rd_en SHALL assert when !fifo_empty, no read in flight, and (!out_valid or out_ready); fifo_rd_data captured into out_data with out_valid=1 exactly one cycle after fifo_rd_en; max throughput one word per two cycles.
REQ-019 out_data/out_valid SHALL hold stable while out_valid && !out_ready; out_valid clears on handshake without new data.
REQ-020 DRAIN ends when fifo_empty, no read in flight, out_valid==0: done pulses 1 cycle, -> IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 abort in any non-IDLE state -> FLUSH: fifo_clr=1 for exactly one cycle, occ, counters, out_valid cleared, -> IDLE; no done pulse. abort and arm same cycle: abort wins.
REQ-023 ovf SHALL stay set until next accepted arm.
REQ-024 pre_num+post_num > 2^c_DEPTH_WIDTH is legal; excess handled by REQ-017.

Reset
REQ-025 rst_n low SHALL force IDLE, occ=0, counters=0, out_data=0, out_valid=0, done=0, ovf=0, busy=0, fifo_clr=0; fifo_wr_en/fifo_rd_en low.
REQ-026 Reset mid-capture SHALL not clear the FIFO via fifo_clr; FIFO reset is driven from the same rst_n by the integrator.

Structure
REQ-027 State encoding localparams SHALL live in a shared package scope_pkg, with FIFO width defaults.
REQ-028 SHALL contain one sub-module, scope_out_stage: one-read-in-flight tracking, out_data register, valid/ready logic.

Verification
REQ-029 pre_num=4, post_num=4, ramp 0..19, trig on sample 10 -> out_data 6,7,8,9,10,11,12,13; done pulse once.
REQ-030 pre_num=0, post_num=3, trig on sample 5 -> out_data 5,6,7 only.
REQ-031 pre_num=1000, post_num=100, depth 1024 -> ovf=1, exactly 1024 words out.
REQ-032 out_ready toggled 1/0 each cycle during DRAIN -> no word lost or duplicated, data held while stalled.
REQ-033 abort during ARMED -> fifo_clr one cycle, busy=0 next cycle, no done, following arm captures correctly.
REQ-034 rst_n pulsed low mid-POST -> all outputs at REQ-025 values asynchronously.
